// File: rtl/fuzzy_pkg.sv
// ---------------------------------------------------------------------------
// fuzzy_pkg
// Shared widths, the sequencer state type and small helpers for the fuzzy
// inference sequencer and its divider.
//   DW      : width of membership degrees, singletons and the result
//   N_RULES : rule count, 3 T sets x 3 dT sets (fixed)
//   SW_W    : sum-of-weights width, 9*255 = 2295 fits
//   SWG_W   : weighted-sum width, 9*255*255 = 585225 fits
//   RUN_LAT : clocks from the start-sampling edge to valid=1
// ---------------------------------------------------------------------------
package fuzzy_pkg;

  localparam int DW      = 8;
  localparam int N_RULES = 9;
  localparam int SW_W    = 12;
  localparam int SWG_W   = 20;
  localparam int RUN_LAT = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RULE = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // The singleton for rule (i,j) sits at slot 3i+j, which is exactly the
  // running rule index, so one index selects the consequent directly.
  function automatic logic [DW-1:0] rule_g(input logic [N_RULES*DW-1:0] gFlat,
                                           input logic [3:0]            idx);
    return gFlat[idx*DW +: DW];
  endfunction

endpackage

// File: rtl/fuzzy_infer_seq_div.sv
// ---------------------------------------------------------------------------
// seq_div
// Restoring divider producing an 8-bit quotient, one bit per clock, MSB
// first, eight clocks after the start pulse. Quotients that would not fit in
// DW bits, and division by zero, read back as all ones.
//   clk, rst  : clock, synchronous active-high reset
//   i_start   : load num/den and begin a division
//   i_abort   : drop any division in progress
//   i_num     : dividend (weighted sum)
//   i_den     : divisor (sum of weights)
//   o_q       : quotient, final once the last iteration edge has passed
//   o_done    : high during the cycle whose edge writes the final bit
// ---------------------------------------------------------------------------
module seq_div
  import fuzzy_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [SWG_W-1:0] i_num,
  input  logic [SW_W-1:0]  i_den,
  output logic [DW-1:0]    o_q,
  output logic             o_done
);

  logic [SWG_W-1:0] r_rem;
  logic [SW_W-1:0]  r_den;
  logic [DW-1:0]    r_q;
  logic [2:0]       r_cnt;
  logic             r_busy;
  logic             r_sat;

  logic [2:0]       w_bitIdx;
  logic [SWG_W:0]   w_dShift;
  logic             w_fits;
  logic             w_ovf;

  // Trial subtraction of the divisor aligned to the current quotient bit,
  // plus the load-time check that flags a quotient too large for DW bits.
  always_comb begin
    w_bitIdx = 3'd7 - r_cnt;
    w_dShift = (SWG_W+1)'(r_den) << w_bitIdx;
    w_fits   = ({1'b0, r_rem} >= w_dShift);
    w_ovf    = (i_den == '0) || (((SWG_W+1)'(i_den) << DW) <= {1'b0, i_num});
  end

  // Iteration register: load on start, then one quotient bit per clock
  // until the counter has covered all eight bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_den  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_sat  <= 1'b0;
    end else if (i_abort) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= i_num;
      r_den  <= i_den;
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
      r_sat  <= w_ovf;
    end else if (r_busy) begin
      if (w_fits) begin
        r_rem         <= r_rem - w_dShift[SWG_W-1:0];
        r_q[w_bitIdx] <= 1'b1;
      end
      r_cnt <= r_cnt + 3'd1;
      if (r_cnt == 3'd7) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_q    = r_sat ? '1 : r_q;
  assign o_done = r_busy && (r_cnt == 3'd7);

endmodule

// File: rtl/fuzzy_infer_seq.sv
// ---------------------------------------------------------------------------
// fuzzy_infer_seq
// Sequencer for the fuzzy inference datapath: snapshots the degrees and
// singletons on start, walks the nine min/MAC rules one per clock, then runs
// the sequential divider for weighted-average defuzzification.
//   clk, rst        : clock, synchronous active-high reset
//   i_start_pulse   : one-cycle run request (ignored while busy)
//   i_init_pulse    : one-cycle abort/clear, wins over start
//   i_mu_T, i_mu_dT : degrees {pos,zero,neg}, neg in the low byte
//   i_g_flat        : singletons, g_ij at slot 3i+j
//   o_G_out         : defuzzified output, held between runs
//   o_busy          : run in progress
//   o_valid         : o_G_out reflects the last completed run
//   o_zero_w        : last run had a total weight of zero
// ---------------------------------------------------------------------------
module fuzzy_infer_seq
  import fuzzy_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start_pulse,
  input  logic                  i_init_pulse,
  input  logic [3*DW-1:0]       i_mu_T,
  input  logic [3*DW-1:0]       i_mu_dT,
  input  logic [N_RULES*DW-1:0] i_g_flat,
  output logic [DW-1:0]         o_G_out,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic                  o_zero_w
);

  state_t r_state, w_nextState;

  logic [3*DW-1:0]       r_muT;
  logic [3*DW-1:0]       r_mudT;
  logic [N_RULES*DW-1:0] r_g;
  logic [1:0]            r_tIdx;
  logic [1:0]            r_dtIdx;
  logic [3:0]            r_ruleIdx;
  logic [SW_W-1:0]       r_sumW;
  logic [SWG_W-1:0]      r_sumWG;
  logic [DW-1:0]         r_G;
  logic                  r_busy;
  logic                  r_valid;
  logic                  r_zeroW;

  logic [DW-1:0]         w_muA;
  logic [DW-1:0]         w_muB;
  logic [DW-1:0]         w_weight;
  logic [DW-1:0]         w_g;
  logic [2*DW-1:0]       w_prod;
  logic [SW_W-1:0]       w_sumWNext;
  logic [SWG_W-1:0]      w_sumWGNext;
  logic                  w_divStart;
  logic                  w_divDone;
  logic [DW-1:0]         w_q;

  // Shared min/MAC unit for the current rule. The divider is loaded with the
  // sums including the last rule, so it starts on the same edge that
  // accumulates rule 8 and the whole run fits in 18 clocks.
  always_comb begin
    w_muA       = r_muT[r_tIdx*DW +: DW];
    w_muB       = r_mudT[r_dtIdx*DW +: DW];
    w_weight    = (w_muA < w_muB) ? w_muA : w_muB;
    w_g         = rule_g(r_g, r_ruleIdx);
    w_prod      = (2*DW)'(w_weight) * (2*DW)'(w_g);
    w_sumWNext  = r_sumW + SW_W'(w_weight);
    w_sumWGNext = r_sumWG + SWG_W'(w_prod);
    w_divStart  = (r_state == RULE) && (r_ruleIdx == 4'd8) && !i_init_pulse;
  end

  seq_div u_div (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_divStart),
    .i_abort (i_init_pulse),
    .i_num   (w_sumWGNext),
    .i_den   (w_sumWNext),
    .o_q     (w_q),
    .o_done  (w_divDone)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Init from any state returns to IDLE and swallows a
  // simultaneous start; DIV hands over to DONE on the divider's last bit.
  always_comb begin
    w_nextState = r_state;
    if (i_init_pulse) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (i_start_pulse) w_nextState = RULE;
        RULE:    if (r_ruleIdx == 4'd8) w_nextState = DIV;
        DIV:     if (w_divDone) w_nextState = DONE;
        DONE:    w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Snapshot, accumulation and result registers. The (i,j) pair is stepped
  // as two small counters so no divide-by-3 is needed on the rule index.
  always_ff @(posedge clk) begin
    if (rst || i_init_pulse) begin
      r_muT     <= '0;
      r_mudT    <= '0;
      r_g       <= '0;
      r_tIdx    <= '0;
      r_dtIdx   <= '0;
      r_ruleIdx <= '0;
      r_sumW    <= '0;
      r_sumWG   <= '0;
      r_G       <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_zeroW   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start_pulse) begin
            r_muT     <= i_mu_T;
            r_mudT    <= i_mu_dT;
            r_g       <= i_g_flat;
            r_tIdx    <= '0;
            r_dtIdx   <= '0;
            r_ruleIdx <= '0;
            r_sumW    <= '0;
            r_sumWG   <= '0;
            r_busy    <= 1'b1;
            r_valid   <= 1'b0;
            r_zeroW   <= 1'b0;
          end
        end
        RULE: begin
          r_sumW  <= w_sumWNext;
          r_sumWG <= w_sumWGNext;
          if (r_ruleIdx == 4'd8) begin
            r_ruleIdx <= '0;
            r_tIdx    <= '0;
            r_dtIdx   <= '0;
          end else begin
            r_ruleIdx <= r_ruleIdx + 4'd1;
            if (r_dtIdx == 2'd2) begin
              r_dtIdx <= '0;
              r_tIdx  <= r_tIdx + 2'd1;
            end else begin
              r_dtIdx <= r_dtIdx + 2'd1;
            end
          end
        end
        DONE: begin
          if (r_sumW != '0) begin
            r_G     <= w_q;
            r_zeroW <= 1'b0;
          end else begin
            r_zeroW <= 1'b1;
          end
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_G_out  = r_G;
  assign o_busy   = r_busy;
  assign o_valid  = r_valid;
  assign o_zero_w = r_zeroW;

endmodule

// File: tb/tb_fuzzy_infer_seq.sv
// ---------------------------------------------------------------------------
// tb_fuzzy_infer_seq
// Self-checking bench for fuzzy_infer_seq: a table of hand-computed runs,
// randomized runs against a rule-level reference model, and hand-written
// sequences for busy-start, mid-run input changes, init and reset.
// ---------------------------------------------------------------------------
module tb_fuzzy_infer_seq;
  import fuzzy_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        startPulse;
  logic        initPulse;
  logic [23:0] muT;
  logic [23:0] mudT;
  logic [71:0] gFlat;
  logic [7:0]  gOut;
  logic        busy;
  logic        valid;
  logic        zeroW;

  int checks = 0;
  int errors = 0;
  int prevG  = 0;

  typedef struct {
    string       name;
    logic [23:0] mT;
    logic [23:0] mD;
    logic [71:0] g;
    int          expG;
    int          expZ;
  } vec_t;

  vec_t vecs[5];

  fuzzy_infer_seq dut (
    .clk           (clk),
    .rst           (rst),
    .i_start_pulse (startPulse),
    .i_init_pulse  (initPulse),
    .i_mu_T        (muT),
    .i_mu_dT       (mudT),
    .i_g_flat      (gFlat),
    .o_G_out       (gOut),
    .o_busy        (busy),
    .o_valid       (valid),
    .o_zero_w      (zeroW)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Hard stop in case some wait is never satisfied.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: every rule weight is the smaller of its two degrees; the
  // output is the truncated weighted mean of the singletons, left unchanged
  // when no rule fires at all.
  function automatic int modelG(input logic [23:0] mT, input logic [23:0] mD,
                                input logic [71:0] g, input int prev, output int zero);
    int sw  = 0;
    int swg = 0;
    int q;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int a = int'(mT[i*8 +: 8]);
        int b = int'(mD[j*8 +: 8]);
        int w = (a < b) ? a : b;
        sw  += w;
        swg += w * int'(g[(3*i+j)*8 +: 8]);
      end
    end
    if (sw == 0) begin
      zero = 1;
      return prev;
    end
    zero = 0;
    q = swg / sw;
    if (q > 255) q = 255;
    return q;
  endfunction

  // Present inputs and pulse start; returns just after the sampling edge.
  task automatic applyStimulus(input logic [23:0] mT, input logic [23:0] mD,
                               input logic [71:0] g);
    muT        = mT;
    mudT       = mD;
    gFlat      = g;
    startPulse = 1'b1;
    @(posedge clk); #1;
    startPulse = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Clocks until valid rises, -1 if it never does within the budget.
  task automatic waitValid(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic runVector(input string name, input logic [23:0] mT, input logic [23:0] mD,
                           input logic [71:0] g, input int expG, input int expZ);
    int lat;
    applyStimulus(mT, mD, g);
    checkOutput({name, " busy@0"}, int'(busy), 1);
    checkOutput({name, " valid@0"}, int'(valid), 0);
    waitValid(lat);
    checkOutput({name, " latency"}, lat, RUN_LAT);
    checkOutput({name, " G_out"}, int'(gOut), expG);
    checkOutput({name, " zero_w"}, int'(zeroW), expZ);
    checkOutput({name, " busy@end"}, int'(busy), 0);
  endtask

  initial begin
    int expG;
    int expZ;
    int lat;
    logic [23:0] rT;
    logic [23:0] rD;
    logic [71:0] rG;

    vecs[0] = '{"single", 24'h00FF00, 24'h00FF00, 72'd50 << 32, 50, 0};
    vecs[1] = '{"blend", 24'h808000, 24'h00FF00, (72'd50 << 32) | (72'd80 << 56), 65, 0};
    vecs[2] = '{"zeroW", 24'h000000, 24'h000000, (72'd50 << 32) | (72'd80 << 56), 65, 1};
    vecs[3] = '{"trunc", 24'h000103, 24'h0000FF, 72'd10 | (72'd11 << 24), 10, 0};
    vecs[4] = '{"full", 24'hFFFFFF, 24'hFFFFFF, {9{8'hFF}}, 255, 0};

    rst        = 1'b1;
    startPulse = 1'b0;
    initPulse  = 1'b0;
    muT        = '0;
    mudT       = '0;
    gFlat      = '0;
    waitCycles(3);
    checkOutput("reset G_out", int'(gOut), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset valid", int'(valid), 0);
    checkOutput("reset zero_w", int'(zeroW), 0);
    rst = 1'b0;
    waitCycles(2);

    $display("[TB] table vectors");
    for (int k = 0; k < 5; k++) begin
      runVector(vecs[k].name, vecs[k].mT, vecs[k].mD, vecs[k].g, vecs[k].expG, vecs[k].expZ);
      prevG = vecs[k].expG;
      waitCycles(1);
    end

    $display("[TB] randomized runs");
    for (int r = 0; r < 24; r++) begin
      rT = 24'($urandom());
      rD = 24'($urandom());
      rG = {8'($urandom()), 32'($urandom()), 32'($urandom())};
      if (r % 6 == 0) rT = '0;
      if (r % 7 == 3) rD = 24'($urandom_range(0, 3));
      expG = modelG(rT, rD, rG, prevG, expZ);
      runVector($sformatf("rand%0d", r), rT, rD, rG, expG, expZ);
      prevG = expG;
      waitCycles(int'($urandom_range(0, 2)));
    end

    $display("[TB] start while busy, inputs changed mid-run");
    applyStimulus(vecs[0].mT, vecs[0].mD, vecs[0].g);
    waitCycles(2);
    muT   = 24'hFFFFFF;
    mudT  = 24'hFFFFFF;
    gFlat = {9{8'hC8}};
    waitCycles(2);
    startPulse = 1'b1;
    waitCycles(1);
    startPulse = 1'b0;
    waitValid(lat);
    checkOutput("busyStart latency", lat, RUN_LAT - 5);
    checkOutput("busyStart G_out", int'(gOut), 50);
    checkOutput("busyStart zero_w", int'(zeroW), 0);
    waitCycles(20);
    checkOutput("busyStart no requeue busy", int'(busy), 0);
    checkOutput("busyStart valid held", int'(valid), 1);
    checkOutput("busyStart G held", int'(gOut), 50);

    $display("[TB] init during divide");
    applyStimulus(vecs[1].mT, vecs[1].mD, vecs[1].g);
    waitCycles(11);
    initPulse = 1'b1;
    waitCycles(1);
    initPulse = 1'b0;
    checkOutput("init busy", int'(busy), 0);
    checkOutput("init valid", int'(valid), 0);
    checkOutput("init G_out", int'(gOut), 0);
    checkOutput("init zero_w", int'(zeroW), 0);
    waitCycles(20);
    checkOutput("init run aborted valid", int'(valid), 0);
    runVector("afterInit", vecs[3].mT, vecs[3].mD, vecs[3].g, 10, 0);

    $display("[TB] init and start together");
    muT        = vecs[1].mT;
    mudT       = vecs[1].mD;
    gFlat      = vecs[1].g;
    initPulse  = 1'b1;
    startPulse = 1'b1;
    waitCycles(1);
    initPulse  = 1'b0;
    startPulse = 1'b0;
    checkOutput("initStart busy", int'(busy), 0);
    checkOutput("initStart valid", int'(valid), 0);
    checkOutput("initStart G_out", int'(gOut), 0);
    waitCycles(20);
    checkOutput("initStart no run valid", int'(valid), 0);

    $display("[TB] reset mid-run");
    applyStimulus(vecs[4].mT, vecs[4].mD, vecs[4].g);
    waitCycles(6);
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    checkOutput("rstRun busy", int'(busy), 0);
    checkOutput("rstRun valid", int'(valid), 0);
    checkOutput("rstRun G_out", int'(gOut), 0);
    waitCycles(20);
    checkOutput("rstRun no completion", int'(valid), 0);
    runVector("zeroAfterRst", 24'h0, 24'h0, vecs[4].g, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
